// File: rtl/ai_mc_pkg.sv
// ai_mc_pkg
//   Shared types and helpers for the memory-controller command arbiter.
//   - arb_state_t : arbiter FSM states (IDLE, SPLIT, ISSUE, DONE)
//   - beat_bytes  : bytes transferred per data beat for a given bus width
package ai_mc_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SPLIT = 2'd1,
    ISSUE = 2'd2,
    DONE  = 2'd3
  } arb_state_t;

  function automatic int beat_bytes(input int data_w);
    return data_w / 8;
  endfunction

endpackage

// File: rtl/ai_mc_rr_pick.sv
// ai_mc_rr_pick
//   Combinational round-robin picker. Searches the request vector cyclically,
//   starting one position after last_grant, and reports the first hit.
// Ports
//   req        in   N_REQ          request vector
//   last_grant in   $clog2(N_REQ)  most recently served requester
//   found      out  1              at least one request is set
//   idx        out  $clog2(N_REQ)  winning requester index
module ai_mc_rr_pick #(
  parameter  int N_REQ = 4,
  localparam int IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] last_grant,
  output logic             found,
  output logic [IDX_W-1:0] idx
);

  logic [IDX_W:0]   sum  [N_REQ];
  logic [IDX_W-1:0] cand [N_REQ];
  logic [N_REQ-1:0] hit;

  // cand[gi] is the requester gi+1 positions after last_grant, wrapped mod N_REQ.
  // sum never reaches 2*N_REQ, so one conditional subtraction is enough.
  generate
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_cand
      assign sum[gi]  = {1'b0, last_grant} + (IDX_W+1)'(gi + 1);
      assign cand[gi] = (sum[gi] >= (IDX_W+1)'(N_REQ)) ?
                        IDX_W'(sum[gi] - (IDX_W+1)'(N_REQ)) : IDX_W'(sum[gi]);
      assign hit[gi]  = req[cand[gi]];
    end
  endgenerate

  // Walk from the far end so the nearest candidate to last_grant wins.
  always_comb begin
    found = |hit;
    idx   = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (hit[k]) idx = cand[k];
    end
  end

endmodule

// File: rtl/ai_mc_cmd_arb.sv
// ai_mc_cmd_arb
//   Round-robin arbiter/splitter sharing one rd/wr command port between N_REQ
//   requesters. Each request is split into chunks of at most MAX_BEATS beats
//   that never cross a BOUNDARY-byte page. Sequencing only, no data path.
// Ports
//   clk, rst                      clock; synchronous active-high reset
//   req_valid/we/addr/len   in    per-requester request (held until req_ready)
//   req_ready               out   one-cycle completion pulse per requester
//   rd_cmd_valid/addr/len   out   read chunk command, rd_cmd_ready handshake
//   wr_cmd_valid/addr/len   out   write chunk command, wr_cmd_ready handshake
//   grant_id                out   requester being served (held in IDLE)
//   busy                    out   FSM not in IDLE
//   arb_error               out   sticky watchdog flag
// Configuration
//   AI_MC_ARB_TIMEOUT_EN : when defined, a watchdog counts ISSUE cycles with
//   ready low and sets arb_error on reaching TIMEOUT_CYC. Otherwise arb_error=0.
module ai_mc_cmd_arb
  import ai_mc_pkg::*;
#(
  parameter int N_REQ       = 4,
  parameter int ADDR_W      = 32,
  parameter int LEN_W       = 16,
  parameter int DATA_W      = 32,
  parameter int MAX_BEATS   = 16,
  parameter int BOUNDARY    = 4096,
  parameter int TIMEOUT_CYC = 256
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_REQ-1:0]           req_valid,
  input  logic [N_REQ-1:0]           req_we,
  input  logic [N_REQ*ADDR_W-1:0]    req_addr,
  input  logic [N_REQ*LEN_W-1:0]     req_len,
  output logic [N_REQ-1:0]           req_ready,
  output logic                       rd_cmd_valid,
  input  logic                       rd_cmd_ready,
  output logic [ADDR_W-1:0]          rd_cmd_addr,
  output logic [LEN_W-1:0]           rd_cmd_len,
  output logic                       wr_cmd_valid,
  input  logic                       wr_cmd_ready,
  output logic [ADDR_W-1:0]          wr_cmd_addr,
  output logic [LEN_W-1:0]           wr_cmd_len,
  output logic [$clog2(N_REQ)-1:0]   grant_id,
  output logic                       busy,
  output logic                       arb_error
);

  localparam int IDX_W      = $clog2(N_REQ);
  localparam int BEAT_BYTES = beat_bytes(DATA_W);
  localparam int OFF_W      = $clog2(BEAT_BYTES);
  localparam int PAGE_W     = $clog2(BOUNDARY);
  localparam logic [ADDR_W-1:0] LOW_MASK = ADDR_W'(BEAT_BYTES - 1);
  localparam logic [PAGE_W:0]   MAX_PAGE = (PAGE_W+1)'(MAX_BEATS);
  localparam logic [LEN_W-1:0]  MAX_LEN  = LEN_W'(MAX_BEATS);

  arb_state_t       state_reg, state_next;
  logic [IDX_W-1:0] last_grant_reg, last_grant_next;
  logic [IDX_W-1:0] cur_id_reg, cur_id_next;
  logic             cur_we_reg, cur_we_next;
  logic [ADDR_W-1:0] cur_addr_reg, cur_addr_next;
  logic [LEN_W-1:0] rem_reg, rem_next;
  logic [LEN_W-1:0] chunk_reg, chunk_next;

  logic [ADDR_W-1:0] addr_arr [N_REQ];
  logic [LEN_W-1:0]  len_arr  [N_REQ];

  generate
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
      assign addr_arr[gi]  = req_addr[gi*ADDR_W +: ADDR_W];
      assign len_arr[gi]   = req_len[gi*LEN_W +: LEN_W];
      assign req_ready[gi] = (state_reg == DONE) && (cur_id_reg == IDX_W'(gi));
    end
  endgenerate

  logic             pick_found;
  logic [IDX_W-1:0] pick_idx;

  ai_mc_rr_pick #(.N_REQ(N_REQ)) u_pick (
    .req        (req_valid),
    .last_grant (last_grant_reg),
    .found      (pick_found),
    .idx        (pick_idx)
  );

  // Beats left before the page boundary. cur_addr is beat-aligned, so this is
  // always at least one beat.
  logic [PAGE_W:0]  page_bytes;
  logic [PAGE_W:0]  page_beats;
  logic [LEN_W-1:0] lim_beats;

  assign page_bytes = (PAGE_W+1)'(BOUNDARY) - {1'b0, cur_addr_reg[PAGE_W-1:0]};
  assign page_beats = page_bytes >> OFF_W;
  assign lim_beats  = (page_beats < MAX_PAGE) ? LEN_W'(page_beats) : MAX_LEN;

  logic cmd_ready;
  assign cmd_ready = cur_we_reg ? wr_cmd_ready : rd_cmd_ready;

  always_comb begin
    state_next      = state_reg;
    last_grant_next = last_grant_reg;
    cur_id_next     = cur_id_reg;
    cur_we_next     = cur_we_reg;
    cur_addr_next   = cur_addr_reg;
    rem_next        = rem_reg;
    chunk_next      = chunk_reg;
    case (state_reg)
      IDLE: begin
        if (pick_found) begin
          cur_id_next   = pick_idx;
          cur_we_next   = req_we[pick_idx];
          cur_addr_next = addr_arr[pick_idx] & ~LOW_MASK;
          rem_next      = len_arr[pick_idx];
          state_next    = (len_arr[pick_idx] == '0) ? DONE : SPLIT;
        end
      end
      SPLIT: begin
        chunk_next = (rem_reg < lim_beats) ? rem_reg : lim_beats;
        state_next = ISSUE;
      end
      ISSUE: begin
        if (cmd_ready) begin
          cur_addr_next = cur_addr_reg + (ADDR_W'(chunk_reg) << OFF_W);
          rem_next      = rem_reg - chunk_reg;
          state_next    = (rem_reg == chunk_reg) ? DONE : SPLIT;
        end
      end
      DONE: begin
        last_grant_next = cur_id_reg;
        state_next      = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      last_grant_reg <= IDX_W'(N_REQ - 1);
      cur_id_reg     <= '0;
      cur_we_reg     <= 1'b0;
      cur_addr_reg   <= '0;
      rem_reg        <= '0;
      chunk_reg      <= '0;
    end else begin
      state_reg      <= state_next;
      last_grant_reg <= last_grant_next;
      cur_id_reg     <= cur_id_next;
      cur_we_reg     <= cur_we_next;
      cur_addr_reg   <= cur_addr_next;
      rem_reg        <= rem_next;
      chunk_reg      <= chunk_next;
    end
  end

  // Idle channel reads zero so downstream sees clean addr/len.
  assign rd_cmd_valid = (state_reg == ISSUE) && !cur_we_reg;
  assign wr_cmd_valid = (state_reg == ISSUE) &&  cur_we_reg;
  assign rd_cmd_addr  = rd_cmd_valid ? cur_addr_reg : '0;
  assign rd_cmd_len   = rd_cmd_valid ? chunk_reg    : '0;
  assign wr_cmd_addr  = wr_cmd_valid ? cur_addr_reg : '0;
  assign wr_cmd_len   = wr_cmd_valid ? chunk_reg    : '0;
  assign grant_id     = cur_id_reg;
  assign busy         = (state_reg != IDLE);

`ifdef AI_MC_ARB_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(TIMEOUT_CYC);

  logic [TO_W-1:0] to_cnt_reg;
  logic            arb_error_reg;

  // Counter saturates at the limit; the error flag sets on the edge the count
  // reaches TIMEOUT_CYC and only reset clears it.
  always_ff @(posedge clk) begin
    if (rst) begin
      to_cnt_reg    <= '0;
      arb_error_reg <= 1'b0;
    end else if ((state_reg == ISSUE) && !cmd_ready) begin
      if (to_cnt_reg != TO_LIMIT) to_cnt_reg <= to_cnt_reg + 1'b1;
      if (to_cnt_reg >= TO_LIMIT - 1'b1) arb_error_reg <= 1'b1;
    end else begin
      to_cnt_reg <= '0;
    end
  end

  assign arb_error = arb_error_reg;
`else
  assign arb_error = 1'b0;
`endif

endmodule
